// File: rtl/mac16_pkg.sv
// Shared types and constants for the MAC16 arbiter slice.
package mac16_pkg;

    localparam int MAC_OPW           = 16;
    localparam int MAC_RESW          = 32;
    localparam int MAC16_LAT_DEFAULT = 4;
    // Wide enough for up to 8 requesters.
    localparam int MAC_TAG_IDW       = 3;

    // One MAC operation: result = a*b + c.
    typedef struct packed {
        logic signed [MAC_OPW-1:0] a;
        logic signed [MAC_OPW-1:0] b;
        logic signed [MAC_OPW-1:0] c;
    } mac_op_t;

    // In-flight marker that travels alongside the MAC pipeline.
    typedef struct packed {
        logic                   valid;
        logic [MAC_TAG_IDW-1:0] id;
    } mac_tag_t;

endpackage

// File: rtl/mac16_arbiter_if.sv
// Requester and MAC-side bus for mac16_arbiter.
// slave = arbiter view, master = requester/MAC environment view.
interface mac16_arbiter_if
    import mac16_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*MAC_OPW-1:0] req_a;
    logic [NUM_REQ*MAC_OPW-1:0] req_b;
    logic [NUM_REQ*MAC_OPW-1:0] req_c;

    logic [MAC_OPW-1:0]         mac_a;
    logic [MAC_OPW-1:0]         mac_b;
    logic [MAC_OPW-1:0]         mac_c;
    logic [MAC_RESW-1:0]        mac_result;

    logic [NUM_REQ-1:0]         rsp_valid;
    logic [IDW-1:0]             rsp_id;
    logic [MAC_RESW-1:0]        rsp_data;

    modport slave (
        input  req_valid, req_a, req_b, req_c, mac_result,
        output req_ready, mac_a, mac_b, mac_c, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_a, req_b, req_c, mac_result,
        input  req_ready, mac_a, mac_b, mac_c, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/mac16_rr_pick.sv
// Rotate-priority picker: first set bit of req at or after ptr, wrapping.
// Purely combinational; any=0 when req is empty.
module mac16_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk N positions starting at ptr; the first hit wins.
    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mac16_arbiter.sv
// Round-robin arbiter/sequencer sharing one MAC16_wrapper among NUM_REQ
// requesters. Operands are registered into the MAC on each grant, and a
// valid/id tag rides a MAC_LAT+1 deep shift register so the response can
// be steered back to the issuer exactly when mac_result is valid.
// Build option: MAC16_ARB_FIXED_PRI_EN gives requester 0 absolute priority.
module mac16_arbiter
    import mac16_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MAC_LAT = MAC16_LAT_DEFAULT,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic            clk,
    input  logic            reset,
    mac16_arbiter_if.slave  bus,
    output logic            busy
);

    logic [IDW-1:0]                    rr_ptr;
    logic [NUM_REQ-1:0]                pick_req;
    logic [NUM_REQ-1:0]                pick_gnt;
    logic [IDW-1:0]                    pick_idx;
    logic                              pick_any;
    logic [NUM_REQ-1:0]                gnt;
    logic [IDW-1:0]                    gnt_idx;
    logic                              gnt_any;
    logic                              ptr_adv;
    mac_op_t [NUM_REQ-1:0]             req_op;
    mac_op_t                           op_q;
    mac_tag_t                          tag_in;
    logic [MAC_LAT:0]                  vld_pipe;
    logic [MAC_LAT:0][MAC_TAG_IDW-1:0] id_pipe;

    // Unpack the flat operand buses into per-requester ops.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_op
        assign req_op[i] = {bus.req_a[i*MAC_OPW +: MAC_OPW],
                            bus.req_b[i*MAC_OPW +: MAC_OPW],
                            bus.req_c[i*MAC_OPW +: MAC_OPW]};
    end

`ifdef MAC16_ARB_FIXED_PRI_EN
    // Requester 0 is handled by the override; the rotation covers 1..N-1.
    assign pick_req = bus.req_valid & ~NUM_REQ'(1);
`else
    assign pick_req = bus.req_valid;
`endif

    mac16_rr_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_pick (
        .req (pick_req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Final grant: optional requester-0 override, all grants blocked in reset.
    always_comb begin
        gnt     = pick_gnt;
        gnt_idx = pick_idx;
        gnt_any = pick_any;
        ptr_adv = pick_any;
`ifdef MAC16_ARB_FIXED_PRI_EN
        if (bus.req_valid[0]) begin
            gnt     = NUM_REQ'(1);
            gnt_idx = '0;
            gnt_any = 1'b1;
            ptr_adv = 1'b0;
        end
`endif
        if (reset) begin
            gnt     = '0;
            gnt_any = 1'b0;
            ptr_adv = 1'b0;
        end
    end

    assign bus.req_ready = gnt;

    // Rotate the search origin to just past the last rotating winner.
    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= '0;
        else if (ptr_adv)
            rr_ptr <= (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end

    // Latch the winner's operands into the MAC; hold them when idle.
    always_ff @(posedge clk) begin
        if (reset)
            op_q <= '0;
        else if (gnt_any)
            op_q <= req_op[gnt_idx];
    end

    assign bus.mac_a = op_q.a;
    assign bus.mac_b = op_q.b;
    assign bus.mac_c = op_q.c;

    assign tag_in.valid = gnt_any;
    assign tag_in.id    = gnt_any ? MAC_TAG_IDW'(gnt_idx) : '0;

    // Tag shift register: stage k holds the op issued k edges ago.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[MAC_LAT-1:0], tag_in.valid};
            id_pipe  <= {id_pipe[MAC_LAT-1:0], tag_in.id};
        end
    end

    // Decode the oldest stage into the one-hot response strobe.
    always_comb begin
        bus.rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++)
            bus.rsp_valid[i] = vld_pipe[MAC_LAT] &&
                               (id_pipe[MAC_LAT] == MAC_TAG_IDW'(i));
    end

    assign bus.rsp_id   = id_pipe[MAC_LAT][IDW-1:0];
    assign bus.rsp_data = bus.mac_result;
    assign busy         = |vld_pipe;

endmodule

// File: tb/tb_mac16_arbiter.sv
// Directed bench for mac16_arbiter with a behavioural 4-cycle MAC model.
module tb_mac16_arbiter;

    localparam int NUM_REQ = 4;
    localparam int MAC_LAT = 4;
    localparam int IDW     = 2;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   nvec = 0;
    int   nerr = 0;

    mac16_arbiter_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus ();

    mac16_arbiter #(
        .NUM_REQ (NUM_REQ),
        .MAC_LAT (MAC_LAT),
        .IDW     (IDW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // External MAC: result valid MAC_LAT edges after the operands change.
    logic signed [31:0] ma, mb, mc;
    logic        [31:0] mpipe [MAC_LAT];
    assign ma = 32'($signed(bus.mac_a));
    assign mb = 32'($signed(bus.mac_b));
    assign mc = 32'($signed(bus.mac_c));
    always @(posedge clk) begin
        mpipe[0] <= ma * mb + mc;
        for (int k = 1; k < MAC_LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign bus.mac_result = mpipe[MAC_LAT-1];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b, input int c);
        bus.req_a[i*16 +: 16] = 16'(a);
        bus.req_b[i*16 +: 16] = 16'(b);
        bus.req_c[i*16 +: 16] = 16'(c);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.req_valid = 4'b1111;
        set_op(0, 1, 1, 1); set_op(1, 2, 2, 2); set_op(2, 3, 3, 3); set_op(3, 4, 4, 4);
        tick; tick;
        nvec++; if (bus.req_ready !== 4'b0000) begin nerr++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
        nvec++; if ({bus.mac_a, bus.mac_b, bus.mac_c} !== 48'h0) begin nerr++; $display("FAIL reset_mac_ops: got %h expected 0", {bus.mac_a, bus.mac_b, bus.mac_c}); end
        nvec++; if (bus.rsp_valid !== 4'b0000) begin nerr++; $display("FAIL reset_rsp_valid: got %b expected 0000", bus.rsp_valid); end
        nvec++; if (bus.rsp_id !== 2'd0) begin nerr++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b expected 0", busy); end
        bus.req_valid = 4'b0000;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_single;
        set_op(2, -5, 3, 10);
        bus.req_valid = 4'b0100;
        #1;
        nvec++; if (bus.req_ready !== 4'b0100) begin nerr++; $display("FAIL single_ready: got %b expected 0100", bus.req_ready); end
        tick;
        bus.req_valid = 4'b0000;
        #1;
        nvec++; if (bus.mac_a !== 16'hFFFB || bus.mac_b !== 16'd3 || bus.mac_c !== 16'd10) begin nerr++; $display("FAIL single_mac_ops: got %h/%h/%h expected fffb/0003/000a", bus.mac_a, bus.mac_b, bus.mac_c); end
        for (int k = 1; k < MAC_LAT; k++) begin
            nvec++; if (bus.rsp_valid !== 4'b0000 || busy !== 1'b1) begin nerr++; $display("FAIL single_wait%0d: got rsp %b busy %b expected 0000 1", k, bus.rsp_valid, busy); end
            tick;
        end
        nvec++; if (bus.rsp_valid !== 4'b0000) begin nerr++; $display("FAIL single_early: got %b expected 0000", bus.rsp_valid); end
        tick;
        nvec++; if (bus.rsp_valid !== 4'b0100) begin nerr++; $display("FAIL single_rsp_valid: got %b expected 0100", bus.rsp_valid); end
        nvec++; if (bus.rsp_id !== 2'd2) begin nerr++; $display("FAIL single_rsp_id: got %0d expected 2", bus.rsp_id); end
        nvec++; if (bus.rsp_data !== 32'hFFFFFFFB) begin nerr++; $display("FAIL single_rsp_data: got %h expected fffffffb", bus.rsp_data); end
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL single_busy_last: got %b expected 1", busy); end
        tick;
        nvec++; if (bus.rsp_valid !== 4'b0000 || busy !== 1'b0) begin nerr++; $display("FAIL single_done: got rsp %b busy %b expected 0000 0", bus.rsp_valid, busy); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_d [4];
        logic [3:0]  vmask;
        logic [3:0]  exp_r;
        exp_d = '{32'd19, 32'd14, 32'hFFFFFFFC, 32'd21000};
        reset = 1'b1;
        tick;
        reset = 1'b0;
        set_op(0, 7, 2, 5); set_op(1, -4, -3, 2); set_op(2, 6, -2, 8); set_op(3, 100, 200, 1000);
        vmask = 4'b1111;
        for (int t = 0; t < 9; t++) begin
            bus.req_valid = vmask;
            #1;
            exp_r = (t < 4) ? 4'(1 << t) : 4'b0000;
            nvec++; if (bus.req_ready !== exp_r) begin nerr++; $display("FAIL b2b_ready t%0d: got %b expected %b", t, bus.req_ready, exp_r); end
            if (t >= 5) begin
                nvec++; if (bus.rsp_valid !== 4'(1 << (t-5)) || bus.rsp_id !== 2'(t-5)) begin nerr++; $display("FAIL b2b_rsp t%0d: got %b id %0d expected %b id %0d", t, bus.rsp_valid, bus.rsp_id, 4'(1 << (t-5)), t-5); end
                nvec++; if (bus.rsp_data !== exp_d[t-5]) begin nerr++; $display("FAIL b2b_data t%0d: got %h expected %h", t, bus.rsp_data, exp_d[t-5]); end
            end else begin
                nvec++; if (bus.rsp_valid !== 4'b0000) begin nerr++; $display("FAIL b2b_quiet t%0d: got %b expected 0000", t, bus.rsp_valid); end
            end
            vmask = vmask & ~exp_r;
            tick;
        end
        bus.req_valid = 4'b0000;
    endtask

    task automatic test_boundary;
        set_op(1, -32768, 2, 0);
        bus.req_valid = 4'b0010;
        #1;
        nvec++; if (bus.req_ready !== 4'b0010) begin nerr++; $display("FAIL bnd_ready0: got %b expected 0010", bus.req_ready); end
        tick;
        set_op(1, 10000, 10000, 0);
        #1;
        nvec++; if (bus.req_ready !== 4'b0010) begin nerr++; $display("FAIL bnd_ready1: got %b expected 0010", bus.req_ready); end
        tick;
        bus.req_valid = 4'b0000;
        tick; tick; tick;
        nvec++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_id !== 2'd1 || bus.rsp_data !== 32'hFFFF0000) begin nerr++; $display("FAIL bnd_neg: got %b id %0d %h expected 0010 id 1 ffff0000", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
        tick;
        nvec++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_id !== 2'd1 || bus.rsp_data !== 32'h05F5E100) begin nerr++; $display("FAIL bnd_pos: got %b id %0d %h expected 0010 id 1 05f5e100", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
        tick;
    endtask

    task automatic test_ptr_wrap;
        logic [3:0] exp_r [3];
`ifdef MAC16_ARB_FIXED_PRI_EN
        exp_r = '{4'b0001, 4'b0001, 4'b0001};
`else
        exp_r = '{4'b1000, 4'b0001, 4'b1000};
`endif
        // Grant requester 2 once so the pointer sits at 3.
        set_op(2, 1, 1, 0);
        bus.req_valid = 4'b0100;
        tick;
        set_op(0, 2, 2, 0); set_op(3, 3, 3, 0);
        for (int t = 0; t < 3; t++) begin
            bus.req_valid = 4'b1001;
            #1;
            nvec++; if (bus.req_ready !== exp_r[t]) begin nerr++; $display("FAIL wrap_ready t%0d: got %b expected %b", t, bus.req_ready, exp_r[t]); end
            tick;
        end
        bus.req_valid = 4'b0000;
        for (int k = 0; k < MAC_LAT + 2; k++) tick;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL wrap_drain: got busy %b expected 0", busy); end
    endtask

    task automatic test_reset_inflight;
        logic [3:0] vmask;
        logic [3:0] exp_r;
        set_op(0, 1, 2, 3); set_op(1, 4, 5, 6); set_op(2, 7, 8, 9);
        vmask = 4'b0111;
        for (int t = 0; t < 3; t++) begin
            bus.req_valid = vmask;
            #1;
            exp_r = 4'(1 << t);
            nvec++; if (bus.req_ready !== exp_r) begin nerr++; $display("FAIL rst_issue t%0d: got %b expected %b", t, bus.req_ready, exp_r); end
            vmask = vmask & ~exp_r;
            tick;
        end
        bus.req_valid = 4'b0000;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b expected 0", busy); end
        nvec++; if ({bus.mac_a, bus.mac_b, bus.mac_c} !== 48'h0) begin nerr++; $display("FAIL rst_mac_ops: got %h expected 0", {bus.mac_a, bus.mac_b, bus.mac_c}); end
        for (int k = 0; k < MAC_LAT + 2; k++) begin
            nvec++; if (bus.rsp_valid !== 4'b0000) begin nerr++; $display("FAIL rst_flushed k%0d: got %b expected 0000", k, bus.rsp_valid); end
            tick;
        end
        set_op(3, 3, 4, 5);
        bus.req_valid = 4'b1000;
        #1;
        nvec++; if (bus.req_ready !== 4'b1000) begin nerr++; $display("FAIL rst_new_ready: got %b expected 1000", bus.req_ready); end
        tick;
        bus.req_valid = 4'b0000;
        for (int k = 0; k < MAC_LAT; k++) tick;
        nvec++; if (bus.rsp_valid !== 4'b1000 || bus.rsp_id !== 2'd3 || bus.rsp_data !== 32'd17) begin nerr++; $display("FAIL rst_new_rsp: got %b id %0d %h expected 1000 id 3 00000011", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
        tick;
    endtask

    task automatic test_fixed_pri;
        logic [3:0] exp_r [4];
`ifdef MAC16_ARB_FIXED_PRI_EN
        exp_r = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_r = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
`endif
        set_op(0, 1, 1, 1); set_op(2, 2, 2, 2);
        for (int t = 0; t < 4; t++) begin
            bus.req_valid = 4'b0101;
            #1;
            nvec++; if (bus.req_ready !== exp_r[t]) begin nerr++; $display("FAIL pri_ready t%0d: got %b expected %b", t, bus.req_ready, exp_r[t]); end
            tick;
        end
        bus.req_valid = 4'b0000;
        for (int k = 0; k < MAC_LAT + 2; k++) tick;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL pri_drain: got busy %b expected 0", busy); end
    endtask

    initial begin
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_c = '0;
        test_reset;
        test_single;
        test_back_to_back;
        test_boundary;
        test_ptr_wrap;
        test_reset_inflight;
        test_fixed_pri;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
